// File: rtl/tluh_pkg.sv
// TL-UH channel bundles and opcodes.
// Shared between the burst splitter and its neighbours.
package tluh_pkg;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_ARITH    = 3'd2;
    localparam logic [2:0] OP_LOGIC    = 3'd3;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_INTENT   = 3'd5;

    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK = 3'd2;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tluh_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [2:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tluh_d2h_t;

endpackage

// File: rtl/tluh_burst_splitter.sv
// Splits TL-UH Get/Put bursts into single-word device accesses,
// one outstanding, and rebuilds the host response stream.
module tluh_burst_splitter
    import tluh_pkg::*;
#(
    parameter int unsigned MaxSize = 4,
    parameter int unsigned BeatW   = MaxSize - 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  tluh_h2d_t tl_h_i,
    output tluh_d2h_t tl_h_o,
    output tluh_h2d_t tl_d_o,
    input  tluh_d2h_t tl_d_i
);

    typedef enum logic [2:0] {
        IDLE, GET, PUT, ERR_GET, ERR_PUT, PASS
    } state_e;

    state_e state_q, state_d;

    logic [2:0]       op_q, param_q, size_q;
    logic [7:0]       src_q;
    logic [31:0]      addr_q, data_q;
    logic [3:0]       mask_q;
    logic [BeatW-1:0] a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
    logic             outst_q, outst_d;
    logic             err_q, err_d;
    logic             a_done_q, a_done_d;
    logic             cap;

    logic [BeatW-1:0] last_beat, d_last_beat;
    logic [31:0]      beat_addr, blk_mask;
    logic             mis, is_get, is_put;
    logic             h_a_ack, h_d_ack, d_a_ack, d_d_ack;
    tluh_h2d_t        cap_a;

    always_comb begin
        last_beat = '0;
        if (size_q >= 3'd2) begin
            last_beat = BeatW'((32'd1 << (size_q - 3'd2)) - 32'd1);
        end
        d_last_beat = (op_q == OP_INTENT) ? '0 : last_beat;
    end

    // Base is block-aligned, so OR-ing the beat offset stays in the block.
    assign beat_addr = addr_q | (32'(a_cnt_q) << 2);
    assign blk_mask  = (32'd1 << tl_h_i.a_size) - 32'd1;
    assign mis       = (tl_h_i.a_size >= 3'd2) &&
                       (|(tl_h_i.a_address & blk_mask));
    assign is_get    = tl_h_i.a_opcode == OP_GET;
    assign is_put    = (tl_h_i.a_opcode == OP_PUT_FULL) ||
                       (tl_h_i.a_opcode == OP_PUT_PART);

    always_comb begin
        state_d  = state_q;
        a_cnt_d  = a_cnt_q;
        d_cnt_d  = d_cnt_q;
        outst_d  = outst_q;
        err_d    = err_q;
        a_done_d = a_done_q;
        cap      = 1'b0;
        tl_h_o   = '0;
        tl_d_o   = '0;

        cap_a           = '0;
        cap_a.a_valid   = 1'b1;
        cap_a.a_opcode  = op_q;
        cap_a.a_param   = param_q;
        cap_a.a_size    = size_q;
        cap_a.a_source  = src_q;
        cap_a.a_address = addr_q;
        cap_a.a_mask    = mask_q;
        cap_a.a_data    = data_q;

        unique case (state_q)
            IDLE: tl_h_o.a_ready = 1'b1;
            GET: begin
                tl_d_o           = cap_a;
                tl_d_o.a_valid   = ~outst_q;
                tl_d_o.a_param   = '0;
                tl_d_o.a_size    = 3'd2;
                tl_d_o.a_address = beat_addr;
                tl_d_o.a_mask    = '1;
                tl_d_o.a_data    = '0;
                tl_d_o.d_ready   = tl_h_i.d_ready;
                tl_h_o.d_valid   = tl_d_i.d_valid;
                tl_h_o.d_opcode  = D_ACK_DATA;
                tl_h_o.d_size    = size_q;
                tl_h_o.d_source  = src_q;
                tl_h_o.d_data    = tl_d_i.d_data;
                tl_h_o.d_error   = tl_d_i.d_error;
            end
            PUT: begin
                tl_d_o           = cap_a;
                tl_d_o.a_valid   = ~outst_q;
                tl_d_o.a_size    = 3'd2;
                tl_d_o.a_address = beat_addr;
                if (a_cnt_q != '0) begin
                    tl_d_o.a_valid  = tl_h_i.a_valid & ~outst_q;
                    tl_d_o.a_mask   = tl_h_i.a_mask;
                    tl_d_o.a_data   = tl_h_i.a_data;
                    tl_h_o.a_ready  = tl_d_i.a_ready & ~outst_q;
                end
                tl_d_o.d_ready = 1'b1;
                if (a_cnt_q == last_beat) begin
                    tl_d_o.d_ready  = tl_h_i.d_ready;
                    tl_h_o.d_valid  = tl_d_i.d_valid;
                    tl_h_o.d_opcode = D_ACK;
                    tl_h_o.d_size   = size_q;
                    tl_h_o.d_source = src_q;
                    tl_h_o.d_error  = err_q | tl_d_i.d_error;
                end
            end
            ERR_GET: begin
                tl_h_o.d_valid  = 1'b1;
                tl_h_o.d_opcode = D_ACK_DATA;
                tl_h_o.d_size   = size_q;
                tl_h_o.d_source = src_q;
                tl_h_o.d_data   = '1;
                tl_h_o.d_error  = 1'b1;
            end
            ERR_PUT: begin
                if (a_cnt_q != last_beat) begin
                    tl_h_o.a_ready  = 1'b1;
                end else begin
                    tl_h_o.d_valid  = 1'b1;
                    tl_h_o.d_opcode = D_ACK;
                    tl_h_o.d_size   = size_q;
                    tl_h_o.d_source = src_q;
                    tl_h_o.d_error  = 1'b1;
                end
            end
            PASS: begin
                tl_d_o = tl_h_i;
                tl_d_o.a_valid = tl_h_i.a_valid & ~a_done_q;
                if (a_cnt_q == '0) begin
                    tl_d_o         = cap_a;
                    tl_d_o.a_valid = ~a_done_q;
                    tl_d_o.d_ready = tl_h_i.d_ready;
                end
                tl_h_o = tl_d_i;
                tl_h_o.a_ready = (a_cnt_q != '0) & ~a_done_q &
                                 tl_d_i.a_ready;
            end
            default: state_d = IDLE;
        endcase

        if (!rst_ni) begin
            tl_h_o.a_ready = 1'b0;
            tl_h_o.d_valid = 1'b0;
            tl_d_o.a_valid = 1'b0;
            tl_d_o.d_ready = 1'b0;
        end

        h_a_ack = tl_h_i.a_valid & tl_h_o.a_ready;
        h_d_ack = tl_h_o.d_valid & tl_h_i.d_ready;
        d_a_ack = tl_d_o.a_valid & tl_d_i.a_ready;
        d_d_ack = tl_d_i.d_valid & tl_d_o.d_ready;

        unique case (state_q)
            IDLE: if (h_a_ack) begin
                cap      = 1'b1;
                a_cnt_d  = '0;
                d_cnt_d  = '0;
                outst_d  = 1'b0;
                err_d    = 1'b0;
                a_done_d = 1'b0;
                unique case (1'b1)
                    is_get & ~mis: state_d = GET;
                    is_get & mis:  state_d = ERR_GET;
                    is_put & ~mis: state_d = PUT;
                    is_put & mis:  state_d = ERR_PUT;
                    default:       state_d = PASS;
                endcase
            end
            GET, PUT: begin
                if (d_a_ack) outst_d = 1'b1;
                if (d_d_ack) begin
                    outst_d = 1'b0;
                    err_d   = err_q | tl_d_i.d_error;
                    a_cnt_d = a_cnt_q + 1'b1;
                    if (a_cnt_q == last_beat) begin
                        a_cnt_d = '0;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            ERR_GET: if (h_d_ack) begin
                a_cnt_d = a_cnt_q + 1'b1;
                if (a_cnt_q == last_beat) begin
                    a_cnt_d = '0;
                    state_d = IDLE;
                end
            end
            ERR_PUT: begin
                if (h_a_ack) a_cnt_d = a_cnt_q + 1'b1;
                if (h_d_ack) state_d = IDLE;
            end
            PASS: begin
                if (d_a_ack) begin
                    a_cnt_d = a_cnt_q + 1'b1;
                    if (a_cnt_q == last_beat) begin
                        a_cnt_d  = '0;
                        a_done_d = 1'b1;
                    end
                end
                if (d_d_ack) begin
                    d_cnt_d = d_cnt_q + 1'b1;
                    if (d_cnt_q == d_last_beat) begin
                        d_cnt_d = '0;
                        if (a_done_d) state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_cnt_q  <= '0;
            d_cnt_q  <= '0;
            outst_q  <= 1'b0;
            err_q    <= 1'b0;
            a_done_q <= 1'b0;
            op_q     <= '0;
            param_q  <= '0;
            size_q   <= '0;
            src_q    <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_cnt_q  <= a_cnt_d;
            d_cnt_q  <= d_cnt_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            a_done_q <= a_done_d;
            if (cap) begin
                op_q    <= tl_h_i.a_opcode;
                param_q <= tl_h_i.a_param;
                size_q  <= tl_h_i.a_size;
                src_q   <= tl_h_i.a_source;
                addr_q  <= tl_h_i.a_address;
                mask_q  <= tl_h_i.a_mask;
                data_q  <= tl_h_i.a_data;
            end
        end
    end

endmodule

// File: tb/tb_tluh_burst_splitter.sv
// Bench for tluh_burst_splitter: directed bursts, a transaction-level
// model of expected device/host traffic, and a per-cycle checker.
module tb_tluh_burst_splitter;
    import tluh_pkg::*;

    logic      clk = 1'b0;
    logic      rst_ni = 1'b0;
    tluh_h2d_t h_i, d_o;
    tluh_d2h_t h_o, d_i;

    always #5 clk = ~clk;

    tluh_burst_splitter dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .tl_h_i (h_i),
        .tl_h_o (h_o),
        .tl_d_o (d_o),
        .tl_d_i (d_i)
    );

    typedef struct {
        logic [2:0]  op, param, size;
        logic [31:0] addr, data;
        logic [3:0]  mask;
        logic [7:0]  src;
        logic        has_data;
    } dev_t;

    typedef struct {
        logic [2:0]  op, size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err, has_data;
    } hst_t;

    dev_t        exp_dev[$];
    hst_t        exp_host[$];
    logic [31:0] rsp_data[$];
    logic        rsp_err[$];

    logic [31:0] bd[4], brd[4];
    logic [3:0]  bm[4];
    logic        berr[4];

    int vectors = 0, miscompares = 0;
    int host_cnt = 0, dev_cnt = 0, outst = 0;
    int h0, d0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int nb(input logic [2:0] s);
        return (s >= 3'd2) ? (1 << (s - 3'd2)) : 1;
    endfunction

    // Expected traffic of one host transaction, from the protocol rules.
    task automatic model(input logic [2:0] op, input logic [2:0] param,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [7:0] src);
        int   n, nd;
        logic mis, e;
        dev_t d;
        hst_t h;
        n   = nb(size);
        mis = (size >= 3'd2) && ((addr % (32'd1 << size)) != 0);
        if (op == OP_GET) begin
            for (int i = 0; i < n; i++) begin
                if (!mis) begin
                    d = '{op: OP_GET, param: 3'd0, size: 3'd2,
                          addr: addr + 32'(4 * i), data: 32'd0,
                          mask: 4'hF, src: src, has_data: 1'b0};
                    exp_dev.push_back(d);
                    rsp_data.push_back(brd[i]);
                    rsp_err.push_back(berr[i]);
                end
                h = '{op: D_ACK_DATA, size: size, src: src,
                      data: mis ? 32'hFFFF_FFFF : brd[i],
                      err: mis ? 1'b1 : berr[i], has_data: 1'b1};
                exp_host.push_back(h);
            end
        end else if (op == OP_PUT_FULL || op == OP_PUT_PART) begin
            e = mis;
            if (!mis) begin
                for (int i = 0; i < n; i++) begin
                    d = '{op: op, param: param, size: 3'd2,
                          addr: addr + 32'(4 * i), data: bd[i],
                          mask: bm[i], src: src, has_data: 1'b1};
                    exp_dev.push_back(d);
                    rsp_data.push_back(32'd0);
                    rsp_err.push_back(berr[i]);
                    e = e | berr[i];
                end
            end
            h = '{op: D_ACK, size: size, src: src, data: 32'd0,
                  err: e, has_data: 1'b0};
            exp_host.push_back(h);
        end else begin
            for (int i = 0; i < n; i++) begin
                d = '{op: op, param: param, size: size, addr: addr,
                      data: bd[i], mask: bm[i], src: src, has_data: 1'b1};
                exp_dev.push_back(d);
            end
            nd = (op == OP_INTENT) ? 1 : n;
            for (int i = 0; i < nd; i++) begin
                rsp_data.push_back(brd[i]);
                rsp_err.push_back(berr[i]);
                h = '{op: (op == OP_INTENT) ? D_HINT_ACK : D_ACK_DATA,
                      size: size, src: src, data: brd[i], err: berr[i],
                      has_data: op != OP_INTENT};
                exp_host.push_back(h);
            end
        end
    endtask

    task automatic host_send(input logic [2:0] op, input logic [2:0] param,
                             input logic [2:0] size, input logic [31:0] addr,
                             input logic [7:0] src);
        int nab, cyc;
        nab = (op == OP_GET || op == OP_INTENT) ? 1 : nb(size);
        for (int i = 0; i < nab; i++) begin
            h_i.a_valid   = 1'b1;
            h_i.a_opcode  = op;
            h_i.a_param   = param;
            h_i.a_size    = size;
            h_i.a_address = addr;
            h_i.a_source  = src;
            h_i.a_mask    = bm[i];
            h_i.a_data    = bd[i];
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!h_o.a_ready && cyc < 200);
            chk("host_a_accept", {31'd0, h_o.a_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        h_i.a_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (exp_dev.size() == 0 && exp_host.size() == 0) break;
        end
        chk({name, "_drain"}, exp_dev.size() + exp_host.size(), 32'd0);
        exp_dev.delete();
        exp_host.delete();
        rsp_data.delete();
        rsp_err.delete();
    endtask

    task automatic clr_beats();
        for (int i = 0; i < 4; i++) begin
            bd[i]   = 32'd0;
            brd[i]  = 32'd0;
            bm[i]   = 4'hF;
            berr[i] = 1'b0;
        end
    endtask

    // Device: one-cycle response to every accepted request.
    initial begin
        logic      a_hs, d_hs, r;
        tluh_h2d_t req;
        d_i = '0;
        d_i.a_ready = 1'b1;
        forever begin
            @(negedge clk);
            r    = rst_ni;
            a_hs = rst_ni && d_o.a_valid && d_i.a_ready;
            d_hs = d_i.d_valid && d_o.d_ready;
            req  = d_o;
            @(posedge clk);
            #1;
            if (!r || d_hs) d_i.d_valid = 1'b0;
            if (a_hs) begin
                d_i.d_valid  = 1'b1;
                d_i.d_source = req.a_source;
                d_i.d_size   = req.a_size;
                if (req.a_opcode == OP_GET || req.a_opcode == OP_ARITH ||
                    req.a_opcode == OP_LOGIC)
                    d_i.d_opcode = D_ACK_DATA;
                else if (req.a_opcode == OP_INTENT)
                    d_i.d_opcode = D_HINT_ACK;
                else
                    d_i.d_opcode = D_ACK;
                d_i.d_data  = (rsp_data.size() > 0) ? rsp_data.pop_front() : 32'd0;
                d_i.d_error = (rsp_err.size() > 0) ? rsp_err.pop_front() : 1'b0;
            end
        end
    end

    // Compare every device request and host response against the model.
    initial begin
        dev_t e;
        hst_t h;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                outst = 0;
                continue;
            end
            if (d_o.a_valid && d_i.a_ready) begin
                chk("dev_one_outstanding", outst, 32'd0);
                if (exp_dev.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dev_unexpected: addr %h, want none", d_o.a_address);
                end else begin
                    e = exp_dev.pop_front();
                    chk("dev_opcode", {29'd0, d_o.a_opcode}, {29'd0, e.op});
                    chk("dev_param", {29'd0, d_o.a_param}, {29'd0, e.param});
                    chk("dev_size", {29'd0, d_o.a_size}, {29'd0, e.size});
                    chk("dev_addr", d_o.a_address, e.addr);
                    chk("dev_mask", {28'd0, d_o.a_mask}, {28'd0, e.mask});
                    chk("dev_source", {24'd0, d_o.a_source}, {24'd0, e.src});
                    if (e.has_data) chk("dev_data", d_o.a_data, e.data);
                end
                dev_cnt++;
                outst++;
            end
            if (d_i.d_valid && d_o.d_ready) outst--;
            if (h_o.d_valid && h_i.d_ready) begin
                if (exp_host.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL host_unexpected: data %h, want none", h_o.d_data);
                end else begin
                    h = exp_host.pop_front();
                    chk("host_opcode", {29'd0, h_o.d_opcode}, {29'd0, h.op});
                    chk("host_size", {29'd0, h_o.d_size}, {29'd0, h.size});
                    chk("host_source", {24'd0, h_o.d_source}, {24'd0, h.src});
                    chk("host_error", {31'd0, h_o.d_error}, {31'd0, h.err});
                    if (h.has_data) chk("host_data", h_o.d_data, h.data);
                end
                host_cnt++;
            end
        end
    end

    initial begin
        int cyc;
        h_i = '0;
        h_i.d_ready = 1'b1;
        clr_beats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_h_a_ready", {31'd0, h_o.a_ready}, 32'd0);
        chk("rst_h_d_valid", {31'd0, h_o.d_valid}, 32'd0);
        chk("rst_d_a_valid", {31'd0, d_o.a_valid}, 32'd0);
        chk("rst_d_d_ready", {31'd0, d_o.d_ready}, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("idle_a_ready", {31'd0, h_o.a_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 4-beat Get, aligned
        clr_beats();
        brd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        model(OP_GET, 3'd0, 3'd4, 32'h20, 8'h11);
        chk("model_t1_addr3", exp_dev[3].addr, 32'h2C);
        chk("model_t1_data2", exp_host[2].data, 32'hA2);
        h0 = host_cnt; d0 = dev_cnt;
        host_send(OP_GET, 3'd0, 3'd4, 32'h20, 8'h11);
        wait_done("t1_get4");
        chk("t1_dev_beats", dev_cnt - d0, 32'd4);
        chk("t1_host_beats", host_cnt - h0, 32'd4);

        // 4-beat PutFullData, error on beat 2
        clr_beats();
        bd   = '{32'd1, 32'd2, 32'd3, 32'd4};
        berr = '{1'b0, 1'b0, 1'b1, 1'b0};
        model(OP_PUT_FULL, 3'd0, 3'd4, 32'h10, 8'h22);
        chk("model_t2_nhost", exp_host.size(), 32'd1);
        chk("model_t2_err", {31'd0, exp_host[0].err}, 32'd1);
        h0 = host_cnt; d0 = dev_cnt;
        host_send(OP_PUT_FULL, 3'd0, 3'd4, 32'h10, 8'h22);
        wait_done("t2_put4");
        chk("t2_dev_beats", dev_cnt - d0, 32'd4);
        chk("t2_host_beats", host_cnt - h0, 32'd1);

        // Misaligned 2-beat Get
        clr_beats();
        model(OP_GET, 3'd0, 3'd3, 32'h04, 8'h33);
        chk("model_t3_ndev", exp_dev.size(), 32'd0);
        chk("model_t3_data1", exp_host[1].data, 32'hFFFF_FFFF);
        h0 = host_cnt; d0 = dev_cnt;
        host_send(OP_GET, 3'd0, 3'd3, 32'h04, 8'h33);
        wait_done("t3_errget");
        chk("t3_dev_beats", dev_cnt - d0, 32'd0);
        chk("t3_host_beats", host_cnt - h0, 32'd2);

        // Misaligned 2-beat Put
        clr_beats();
        bd = '{32'h5, 32'h6, 32'h0, 32'h0};
        model(OP_PUT_FULL, 3'd0, 3'd3, 32'h14, 8'h34);
        h0 = host_cnt; d0 = dev_cnt;
        host_send(OP_PUT_FULL, 3'd0, 3'd3, 32'h14, 8'h34);
        wait_done("t3b_errput");
        chk("t3b_dev_beats", dev_cnt - d0, 32'd0);
        chk("t3b_host_beats", host_cnt - h0, 32'd1);

        // Single Get with host d_ready held low
        clr_beats();
        brd[0] = 32'h55;
        model(OP_GET, 3'd0, 3'd2, 32'h08, 8'h44);
        h0 = host_cnt; d0 = dev_cnt;
        h_i.d_ready = 1'b0;
        host_send(OP_GET, 3'd0, 3'd2, 32'h08, 8'h44);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!h_o.d_valid && cyc < 20);
        chk("t4_dvalid_seen", {31'd0, h_o.d_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("t4_dev_d_ready_low", {31'd0, d_o.d_ready}, 32'd0);
            chk("t4_data_stable", h_o.d_data, 32'h55);
        end
        @(posedge clk);
        #1 h_i.d_ready = 1'b1;
        wait_done("t4_stall");
        chk("t4_host_beats", host_cnt - h0, 32'd1);

        // Atomic pass-through
        clr_beats();
        bd[0]  = 32'h1234;
        bm[0]  = 4'b0110;
        brd[0] = 32'h99;
        model(OP_ARITH, 3'd4, 3'd2, 32'h30, 8'h55);
        h0 = host_cnt; d0 = dev_cnt;
        host_send(OP_ARITH, 3'd4, 3'd2, 32'h30, 8'h55);
        wait_done("t5_pass");
        @(negedge clk);
        chk("t5_back_idle", {31'd0, h_o.a_ready}, 32'd1);
        chk("t5_host_beats", host_cnt - h0, 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a 4-beat Get
        clr_beats();
        brd = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        model(OP_GET, 3'd0, 3'd4, 32'h40, 8'h66);
        h0 = host_cnt;
        host_send(OP_GET, 3'd0, 3'd4, 32'h40, 8'h66);
        for (int c = 0; c < 200; c++) begin
            if (host_cnt - h0 >= 2) break;
            @(posedge clk);
            #1;
        end
        chk("t6_two_beats", host_cnt - h0, 32'd2);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("t6_h_a_ready", {31'd0, h_o.a_ready}, 32'd0);
        chk("t6_h_d_valid", {31'd0, h_o.d_valid}, 32'd0);
        chk("t6_d_a_valid", {31'd0, d_o.a_valid}, 32'd0);
        chk("t6_d_d_ready", {31'd0, d_o.d_ready}, 32'd0);
        @(posedge clk);
        #1;
        exp_dev.delete();
        exp_host.delete();
        rsp_data.delete();
        rsp_err.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_rst", {31'd0, h_o.a_ready}, 32'd1);
        chk("t6_no_d_valid", {31'd0, h_o.d_valid}, 32'd0);
        @(posedge clk);
        #1;
        clr_beats();
        brd[0] = 32'hC5;
        model(OP_GET, 3'd0, 3'd2, 32'h44, 8'h77);
        h0 = host_cnt; d0 = dev_cnt;
        host_send(OP_GET, 3'd0, 3'd2, 32'h44, 8'h77);
        wait_done("t6_fresh_get");
        chk("t6_dev_beats", dev_cnt - d0, 32'd1);
        chk("t6_host_beats", host_cnt - h0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
